// File: rtl/ln_seq_pkg.sv
// Shared types for the linearizer/normalizer request sequencer.
// Holds the FSM state encoding and the default sample/result width.
package ln_seq_pkg;

  localparam int LN_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    START    = 2'd1,
    WAIT_ACK = 2'd2,
    HOLD     = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ln_ack_capture.sv
// Per-channel ack latch: captures the first result after a clear and ignores repeats.
// Latency: flag/data registered one cycle after the ack; done_nxt is the same-cycle view.
module ln_ack_capture #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         ack,
  input  logic [W-1:0] result,
  output logic         flag,
  output logic         done_nxt,
  output logic [W-1:0] data
);

  logic         flag_q, flag_d;
  logic [W-1:0] data_q, data_d;
  logic         hit;

  assign hit = en && ack && !flag_q;

  always_comb begin
    flag_d = flag_q;
    data_d = data_q;
    if (clr) begin
      flag_d = 1'b0;
      data_d = '0;
    end else if (hit) begin
      flag_d = 1'b1;
      data_d = result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q <= 1'b0;
      data_q <= '0;
    end else begin
      flag_q <= flag_d;
      data_q <= data_d;
    end
  end

  assign flag     = flag_q;
  assign done_nxt = flag_q || hit;
  assign data     = data_q;

endmodule

// File: rtl/ln_request_sequencer.sv
// Issues one I/V operand pair to the core, pairs the two acks, and hands the result downstream.
// Latency: Begin one cycle after accept, OUT_VALID one cycle after last ack; holds until OUT_READY.
module ln_request_sequencer
  import ln_seq_pkg::*;
#(
  parameter int W              = LN_W,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic         CLK,
  input  logic         RST_SEQ_FF,
  input  logic         SAMPLE_VALID,
  output logic         SAMPLE_READY,
  input  logic [W-1:0] SAMPLE_I,
  input  logic [W-1:0] SAMPLE_V,
  output logic [W-1:0] I,
  output logic [W-1:0] V,
  output logic         Begin_FSM_I,
  output logic         Begin_FSM_V,
  input  logic         ACK_I,
  input  logic         ACK_V,
  input  logic [W-1:0] RESULT_I,
  input  logic [W-1:0] RESULT_V,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [W-1:0] OUT_I,
  output logic [W-1:0] OUT_V,
  output logic         TIMEOUT_ERR
);

  localparam int             CW       = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]  CNT_MAX  = {CW{1'b1}};

  seq_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  i_q, i_d;
  logic [W-1:0]  v_q, v_d;
  logic          begin_q, begin_d;
  logic          out_valid_q, out_valid_d;
  logic          timeout_q, timeout_d;

  logic          cap_clr, cap_en;
  logic          flag_i, flag_v;
  logic          done_i, done_v;

  ln_ack_capture #(.W(W)) cap_i (
    .clk      (CLK),
    .rst      (RST_SEQ_FF),
    .clr      (cap_clr),
    .en       (cap_en),
    .ack      (ACK_I),
    .result   (RESULT_I),
    .flag     (flag_i),
    .done_nxt (done_i),
    .data     (OUT_I)
  );

  ln_ack_capture #(.W(W)) cap_v (
    .clk      (CLK),
    .rst      (RST_SEQ_FF),
    .clr      (cap_clr),
    .en       (cap_en),
    .ack      (ACK_V),
    .result   (RESULT_V),
    .flag     (flag_v),
    .done_nxt (done_v),
    .data     (OUT_V)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    i_d         = i_q;
    v_d         = v_q;
    begin_d     = 1'b0;
    out_valid_d = 1'b0;
    timeout_d   = 1'b0;
    cap_clr     = 1'b0;
    cap_en      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (SAMPLE_VALID) begin
          i_d     = SAMPLE_I;
          v_d     = SAMPLE_V;
          begin_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cap_clr = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        cap_en = 1'b1;
        // A completing ack outranks the watchdog in the same cycle.
        if (done_i && done_v) begin
          out_valid_d = 1'b1;
          state_d     = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          cap_clr   = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (OUT_READY) begin
          state_d = IDLE;
        end else begin
          out_valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST_SEQ_FF) begin
    if (RST_SEQ_FF) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      i_q         <= '0;
      v_q         <= '0;
      begin_q     <= 1'b0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      i_q         <= i_d;
      v_q         <= v_d;
      begin_q     <= begin_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  assign SAMPLE_READY = (state_q == IDLE);
  assign I            = i_q;
  assign V            = v_q;
  assign Begin_FSM_I  = begin_q;
  assign Begin_FSM_V  = begin_q;
  assign OUT_VALID    = out_valid_q;
  assign TIMEOUT_ERR  = timeout_q;

endmodule

// File: doc/ln_request_sequencer.md
# ln_request_sequencer

Initiator-side sequencer for the linearizer/normalizer core. It accepts paired current/voltage samples from the acquisition front end, latches them onto the core's `I`/`V` inputs, and pulses `Begin_FSM_I`/`Begin_FSM_V`. It then collects the independently arriving `ACK_I`/`ACK_V` with their `RESULT_I`/`RESULT_V`, and presents one paired result to the downstream consumer over a valid/ready handshake. A cycle-bounded watchdog recovers from a core that never acknowledges.

## Interface
Parameters:
- `W`, 32, sample and result width in bits.
- `TIMEOUT_CYCLES`, 256, maximum number of WAIT_ACK cycles before abort; legal range ≥ 2.

Ports:
- `CLK`  in  1  sole clock; all logic on the rising edge.
- `RST_SEQ_FF`  in  1  asynchronous, active-high reset.
- `SAMPLE_VALID`  in  1  upstream sample pair is valid.
- `SAMPLE_READY`  out  1  sequencer can accept a sample pair.
- `SAMPLE_I`, `SAMPLE_V`  in  W  upstream current and voltage words.
- `I`, `V`  out  W  operands driven to the core.
- `Begin_FSM_I`, `Begin_FSM_V`  out  1  one-cycle start pulses to the core.
- `ACK_I`, `ACK_V`  in  1  one-cycle completion pulses from the core.
- `RESULT_I`, `RESULT_V`  in  W  core results; valid only in the cycle of the matching ACK.
- `OUT_VALID`  out  1  paired result available.
- `OUT_READY`  in  1  downstream accepts the result.
- `OUT_I`, `OUT_V`  out  W  captured results.
- `TIMEOUT_ERR`  out  1  one-cycle pulse on watchdog abort.

## Operation
- States: IDLE, START, WAIT_ACK, HOLD.
- IDLE:
  - `SAMPLE_READY`=1.
  - On `SAMPLE_VALID`, register `SAMPLE_I`/`SAMPLE_V` into `I`/`V` and go to START.
- START:
  - `Begin_FSM_I`=`Begin_FSM_V`=1 for exactly this cycle.
  - Clear both ack flags and the watchdog counter.
  - Go to WAIT_ACK.
- WAIT_ACK:
  - On `ACK_I` with flag_i=0, capture `RESULT_I` into `OUT_I` and set flag_i. `ACK_V` is handled the same way into `OUT_V`/flag_v.
  - A repeated ACK for a channel whose flag is already set is ignored; the first capture is kept.
  - When both flags are set (counting acks that arrive this cycle, including simultaneous `ACK_I`/`ACK_V`), go to HOLD.
  - Otherwise the counter increments. If it equals `TIMEOUT_CYCLES`-1 and the pair is still incomplete, pulse `TIMEOUT_ERR`, discard any partial capture, and go to IDLE.
  - When the final ack and the timeout coincide, the ack wins: go to HOLD, no error.
- HOLD:
  - `OUT_VALID`=1; `OUT_I`/`OUT_V` stay stable.
  - On `OUT_READY`, go to IDLE.
- `I`/`V` hold their value from the IDLE capture until the next accepted sample; they never change during START or WAIT_ACK.
- ACK pulses in IDLE, START or HOLD are ignored (a late ack after an abort is dropped).
- Watchdog counter width: `$clog2(TIMEOUT_CYCLES)`; it saturates and never wraps.

## Timing
- Reset (async assert, sync release):
  - State goes to IDLE.
  - `SAMPLE_READY`=1.
  - `Begin_FSM_*`=0, `OUT_VALID`=0, `TIMEOUT_ERR`=0.
  - `I`, `V`, `OUT_I`, `OUT_V`=0; flags and counter cleared.
- Reset mid-transaction aborts it with no `TIMEOUT_ERR` pulse.
- Sample accepted at edge t → `Begin_FSM_*` high during cycle t+1 → WAIT_ACK from t+2.
- Last ACK seen at edge a → `OUT_VALID`=1 from cycle a+1.
- `OUT_VALID`&`OUT_READY` at edge h → `SAMPLE_READY`=1 from cycle h+1.
- Minimum sample-to-sample spacing: 4 cycles (zero-latency core plus immediate `OUT_READY`).
- Outputs are registered with no combinational input-to-output path, except `SAMPLE_READY`, which decodes the state only.

## Structure
- Package `ln_seq_pkg`: state enum (IDLE=2'd0, START=2'd1, WAIT_ACK=2'd2, HOLD=2'd3) and the default `W`=32.
- Sub-module `ln_ack_capture`, instantiated per channel:
  - Inputs: clear, enable, ack, result.
  - Outputs: flag and the result register.
  - Keeps the I and V paths identical.
- The top level holds the FSM, the watchdog and the operand registers.

## Test plan
- Reset held 10 cycles, then released:
  - All outputs at their reset values; `SAMPLE_READY`=1.
  - No Begin pulse without `SAMPLE_VALID`.
- Sample I=32'hFD28E4FA, V=32'hB0BCEE61; core acks both in the same cycle, 5 cycles after Begin, with RESULT_I=32'h3F800000, RESULT_V=32'hC0490FDB:
  - `OUT_VALID` one cycle later with those values.
  - `I`/`V` stable throughout.
- `ACK_V` 3 cycles after Begin, `ACK_I` 40 cycles after; a second `ACK_V` carrying a different result arrives in between:
  - `OUT_V` holds the first result.
  - `OUT_VALID` asserts only after `ACK_I`.
- `TIMEOUT_CYCLES`=8, only `ACK_I` delivered:
  - `TIMEOUT_ERR` pulses once at WAIT_ACK cycle 8; `OUT_VALID` never asserts.
  - Return to IDLE; a later stray `ACK_V` is ignored.
- `OUT_READY` held low 20 cycles with `SAMPLE_VALID` continuously high:
  - `OUT_VALID` and data held, `SAMPLE_READY`=0, no new Begin pulse.
  - Release → next sample is accepted one cycle later.
- `RST_SEQ_FF` asserted asynchronously mid WAIT_ACK:
  - Immediate return to reset values; no `TIMEOUT_ERR`, no `OUT_VALID`.
